// File: rtl/platform_scheduler_if.sv
// ---------------------------------------------------------------------------
// platform_scheduler_if
//   Bundles the frame strobe, scroll request, indexed read port and status
//   outputs of the platform scheduler.
//   master : player-motion / colour-mapper side (drives frame_clk,
//            scroll_amt, rd_idx; observes everything else)
//   slave  : the scheduler itself
//   Signals:
//     frame_clk  - vsync-rate strobe, asynchronous to Clk
//     scroll_amt - pixels to scroll this frame (0..31)
//     rd_idx     - slot to read
//     rd_X/rd_Y  - registered position of slot rd_idx
//     busy       - INIT or UPDATE in progress
//     done       - one-cycle pulse at end of an update sweep
//     overrun    - one-cycle pulse when a frame edge is dropped
//     height     - saturating total of applied scroll amounts
// ---------------------------------------------------------------------------
interface platform_scheduler_if #(
    parameter int IW = 4
);
    logic          frame_clk;
    logic [4:0]    scroll_amt;
    logic [IW-1:0] rd_idx;
    logic [9:0]    rd_X;
    logic [9:0]    rd_Y;
    logic          busy;
    logic          done;
    logic          overrun;
    logic [15:0]   height;

    modport master (
        output frame_clk, scroll_amt, rd_idx,
        input  rd_X, rd_Y, busy, done, overrun, height
    );

    modport slave (
        input  frame_clk, scroll_amt, rd_idx,
        output rd_X, rd_Y, busy, done, overrun, height
    );
endinterface

// File: rtl/platform_scheduler.sv
// ---------------------------------------------------------------------------
// platform_scheduler
//   Owns the Doodle Jump platform table (NUM_PLAT slots of X/Y). Fills the
//   table after reset, then once per frame scrolls every slot down by the
//   requested amount, recycling slots that fall off the bottom back to the
//   top with a fresh pseudo-random X. Keeps a saturating climb height.
//   Ports:
//     Clk   - system clock
//     Reset - asynchronous active-low reset
//     bus   - platform_scheduler_if.slave (frame strobe, scroll amount,
//             indexed read port, busy/done/overrun, height)
// ---------------------------------------------------------------------------
module platform_scheduler #(
    parameter int NUM_PLAT = 16,
    parameter int SPACING  = 30,
    parameter int Y_OFFSET = 15,
    parameter int SCREEN_H = 480,
    parameter int X_MIN    = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    platform_scheduler_if.slave   bus
);
    localparam int IW = $clog2(NUM_PLAT);

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [4:0]    s;

    logic [9:0] x_tab [NUM_PLAT];
    logic [9:0] y_tab [NUM_PLAT];

    // Free-running x^9+x^5+1 LFSR; seeded non-zero so it never locks up.
    logic [8:0] lfsr;
    logic [9:0] raw_x;

    assign raw_x = {1'b0, lfsr} + 10'(X_MIN);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) lfsr <= 9'h1FF;
        else        lfsr <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    end

    // frame_clk is asynchronous: two flops to resolve metastability, a third
    // for edge detection, and the edge itself registered.
    logic f_s1, f_s2, f_s3, fe;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            f_s1 <= 1'b0;
            f_s2 <= 1'b0;
            f_s3 <= 1'b0;
            fe   <= 1'b0;
        end else begin
            f_s1 <= bus.frame_clk;
            f_s2 <= f_s1;
            f_s3 <= f_s2;
            fe   <= f_s2 & ~f_s3;
        end
    end

    // Per-slot datapath for the current sweep index.
    logic        last;
    logic [10:0] ny;
    logic        wrap;
    logic [9:0]  init_y;
    logic [16:0] h_sum;

    assign last   = (idx == IW'(NUM_PLAT - 1));
    assign ny     = {1'b0, y_tab[idx]} + {6'd0, s};
    assign wrap   = (ny >= 11'(SCREEN_H));
    assign init_y = 10'(Y_OFFSET + SPACING * int'(idx));
    assign h_sum  = {1'b0, bus.height} + {12'd0, bus.scroll_amt};

    // NOTE: the slot table is plain storage with no reset; INIT rewrites
    // every slot after reset, so clearing it would only cost logic.
    always_ff @(posedge Clk) begin
        if (state == ST_INIT) begin
            x_tab[idx] <= raw_x;
            y_tab[idx] <= init_y;
        end else if (state == ST_UPDATE) begin
            if (wrap) begin
                // Wrap rather than reset to 0 so vertical pitch is kept.
                y_tab[idx] <= 10'(ny - 11'(SCREEN_H));
                x_tab[idx] <= raw_x;
            end else begin
                y_tab[idx] <= ny[9:0];
            end
        end
    end

    // Read port: registered, read-before-write against the sweep writes.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            bus.rd_X <= '0;
            bus.rd_Y <= '0;
        end else begin
            bus.rd_X <= x_tab[bus.rd_idx];
            bus.rd_Y <= y_tab[bus.rd_idx];
        end
    end

    // Control FSM. busy/done/overrun are registered from the state held
    // before the edge, so they stay low in reset and busy falls exactly as
    // done rises.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_INIT;
            idx         <= '0;
            s           <= '0;
            bus.height  <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.overrun <= 1'b0;
        end else begin
            bus.busy    <= (state == ST_INIT) || (state == ST_UPDATE);
            bus.done    <= (state == ST_DONE);
            bus.overrun <= fe && (state != ST_IDLE);
            case (state)
                ST_INIT: begin
                    idx <= idx + IW'(1);
                    if (last) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (fe) begin
                        s          <= bus.scroll_amt;
                        bus.height <= h_sum[16] ? 16'hFFFF : h_sum[15:0];
                        idx        <= '0;
                        state      <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    idx <= idx + IW'(1);
                    if (last) state <= ST_DONE;
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_platform_scheduler.sv
// ---------------------------------------------------------------------------
// tb_platform_scheduler
//   Directed bench for platform_scheduler: reset/INIT contents, read port,
//   plain scroll, wrap/recycle, overrun, zero scroll, reset mid-sweep and
//   height saturation.
// ---------------------------------------------------------------------------
module tb_platform_scheduler;
    localparam int NP = 16;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    platform_scheduler_if #(.IW(4)) bus ();

    platform_scheduler dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] exp_x [NP];
    logic [9:0] exp_y [NP];

    function automatic logic [8:0] lfsr_next(input logic [8:0] q);
        return {q[7:0], q[8] ^ q[4]};
    endfunction

    // Reference LFSR, reset and stepped alongside the design.
    logic [8:0] m_lfsr;
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) m_lfsr <= 9'h1FF;
        else        m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic init_expect();
        logic [8:0] q;
        q = 9'h1FF;
        for (int i = 0; i < NP; i++) begin
            exp_x[i] = {1'b0, q} + 10'd8;
            exp_y[i] = 10'(15 + 30 * i);
            q = lfsr_next(q);
        end
    endtask

    task automatic read_slot(input int idx, output logic [9:0] x, output logic [9:0] y);
        @(negedge Clk);
        bus.rd_idx = 4'(idx);
        @(negedge Clk);
        x = bus.rd_X;
        y = bus.rd_Y;
    endtask

    // One frame: raise frame_clk, optionally re-raise it at cycle second_rise,
    // and record what the outputs do over ncyc cycles (sampled 1 ns after
    // each rising edge).
    task automatic run_frame(input logic [4:0] amt, input int second_rise, input int ncyc,
                             output int dcnt, output int dfirst, output int ocnt,
                             output logic [8:0] lf19, output logic [9:0] y20,
                             output logic [9:0] y21);
        dcnt = 0; dfirst = 0; ocnt = 0; lf19 = '0; y20 = '0; y21 = '0;
        @(negedge Clk);
        bus.scroll_amt = amt;
        bus.frame_clk  = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge Clk);
            #1;
            if (n == 3 || (second_rise != 0 && n == second_rise + 3)) bus.frame_clk = 1'b0;
            if (second_rise != 0 && n == second_rise) bus.frame_clk = 1'b1;
            if (bus.done) begin
                dcnt++;
                if (dfirst == 0) dfirst = n;
            end
            if (bus.overrun) ocnt++;
            if (n == 19) lf19 = m_lfsr;
            if (n == 20) y20 = bus.rd_Y;
            if (n == 21) y21 = bus.rd_Y;
        end
    endtask

    task automatic check_table(input string tag);
        logic [9:0] x, y;
        for (int i = 0; i < NP; i++) begin
            read_slot(i, x, y);
            n_checks++;
            if (x !== exp_x[i] || y !== exp_y[i]) begin
                n_fail++;
                $display("FAIL %s slot %0d: got X=%0d Y=%0d expected X=%0d Y=%0d",
                         tag, i, x, y, exp_x[i], exp_y[i]);
            end
        end
    endtask

    task automatic check_init_points(input string tag);
        logic [9:0] x, y;
        int idxs [4] = '{0, 1, 2, 15};
        logic [9:0] hx [4] = '{10'd519, 10'd518, 10'd516, 10'd0};
        logic [9:0] hy [4] = '{10'd15, 10'd45, 10'd75, 10'd465};
        for (int k = 0; k < 4; k++) begin
            read_slot(idxs[k], x, y);
            n_checks++;
            if (y !== hy[k] || (k < 3 && x !== hx[k]) || (k == 3 && x !== exp_x[15])) begin
                n_fail++;
                $display("FAIL %s slot %0d: got X=%0d Y=%0d expected X=%0d Y=%0d", tag, idxs[k],
                         x, y, (k < 3) ? hx[k] : exp_x[15], hy[k]);
            end
        end
    endtask

    task automatic test_reset();
        int busy_cnt;
        bus.frame_clk = 1'b0; bus.scroll_amt = '0; bus.rd_idx = '0;
        #1 Reset = 1'b0;
        repeat (2) @(negedge Clk);
        n_checks++;
        if ({bus.rd_X, bus.rd_Y, bus.busy, bus.done, bus.overrun, bus.height} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got X=%0d Y=%0d busy=%0b done=%0b ovr=%0b h=%0d expected all 0",
                     bus.rd_X, bus.rd_Y, bus.busy, bus.done, bus.overrun, bus.height);
        end
        Reset = 1'b1;
        busy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (bus.busy) busy_cnt++;
        end
        n_checks++;
        if (busy_cnt !== 16) begin
            n_fail++;
            $display("FAIL init_busy_cycles: got %0d expected 16", busy_cnt);
        end
        init_expect();
        check_init_points("init_values");
    endtask

    task automatic test_read_port();
        check_table("read_port");
    endtask

    task automatic test_scroll();
        int dc, df, oc; logic [8:0] lf; logic [9:0] a, b;
        run_frame(5'd10, 0, 30, dc, df, oc, lf, a, b);
        n_checks++;
        if (dc !== 1 || df !== 21) begin
            n_fail++;
            $display("FAIL scroll_done: got count=%0d at=%0d expected count=1 at=21", dc, df);
        end
        n_checks++;
        if (bus.height !== 16'd10) begin
            n_fail++;
            $display("FAIL scroll_height: got %0d expected 10", bus.height);
        end
        for (int i = 0; i < NP; i++) exp_y[i] = exp_y[i] + 10'd10;
        check_table("scroll_table");
    endtask

    task automatic test_wrap();
        int dc, df, oc; logic [8:0] lf; logic [9:0] y_old, y_new, x, y;
        @(negedge Clk); Reset = 1'b0;
        @(negedge Clk); Reset = 1'b1;
        repeat (20) @(negedge Clk);
        init_expect();
        bus.rd_idx = 4'd15;
        run_frame(5'd20, 0, 30, dc, df, oc, lf, y_old, y_new);
        n_checks++;
        if (y_old !== 10'd465) begin
            n_fail++;
            $display("FAIL wrap_read_during_write: got Y=%0d expected 465", y_old);
        end
        n_checks++;
        if (y_new !== 10'd5) begin
            n_fail++;
            $display("FAIL wrap_read_after_write: got Y=%0d expected 5", y_new);
        end
        read_slot(15, x, y);
        n_checks++;
        if (y !== 10'd5 || x !== ({1'b0, lf} + 10'd8)) begin
            n_fail++;
            $display("FAIL wrap_slot15: got X=%0d Y=%0d expected X=%0d Y=5", x, y, {1'b0, lf} + 10'd8);
        end
        read_slot(14, x, y);
        n_checks++;
        if (y !== 10'd455 || x !== exp_x[14]) begin
            n_fail++;
            $display("FAIL wrap_slot14: got X=%0d Y=%0d expected X=%0d Y=455", x, y, exp_x[14]);
        end
        for (int i = 0; i < NP - 1; i++) exp_y[i] = exp_y[i] + 10'd20;
        exp_y[15] = 10'd5;
        exp_x[15] = {1'b0, lf} + 10'd8;
        check_table("wrap_table");
        n_checks++;
        if (bus.height !== 16'd20) begin
            n_fail++;
            $display("FAIL wrap_height: got %0d expected 20", bus.height);
        end
    endtask

    task automatic test_overrun();
        int dc, df, oc; logic [8:0] lf; logic [9:0] a, b;
        run_frame(5'd5, 8, 40, dc, df, oc, lf, a, b);
        n_checks++;
        if (oc !== 1) begin
            n_fail++;
            $display("FAIL overrun_pulses: got %0d expected 1", oc);
        end
        n_checks++;
        if (dc !== 1) begin
            n_fail++;
            $display("FAIL overrun_done_count: got %0d expected 1", dc);
        end
        n_checks++;
        if (bus.height !== 16'd25) begin
            n_fail++;
            $display("FAIL overrun_height: got %0d expected 25", bus.height);
        end
        for (int i = 0; i < NP; i++) exp_y[i] = exp_y[i] + 10'd5;
        check_table("overrun_table");
    endtask

    task automatic test_zero_scroll();
        int dc, df, oc; logic [8:0] lf; logic [9:0] a, b;
        run_frame(5'd0, 0, 30, dc, df, oc, lf, a, b);
        n_checks++;
        if (dc !== 1 || df !== 21) begin
            n_fail++;
            $display("FAIL zero_done: got count=%0d at=%0d expected count=1 at=21", dc, df);
        end
        n_checks++;
        if (bus.height !== 16'd25) begin
            n_fail++;
            $display("FAIL zero_height: got %0d expected 25", bus.height);
        end
        check_table("zero_table");
    endtask

    task automatic test_reset_mid_update();
        @(negedge Clk);
        bus.scroll_amt = 5'd10;
        bus.frame_clk  = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            @(posedge Clk);
            #1;
            if (n == 3) bus.frame_clk = 1'b0;
        end
        Reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.rd_X, bus.rd_Y, bus.busy, bus.done, bus.overrun, bus.height} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got X=%0d Y=%0d busy=%0b done=%0b ovr=%0b h=%0d expected all 0",
                     bus.rd_X, bus.rd_Y, bus.busy, bus.done, bus.overrun, bus.height);
        end
        @(negedge Clk); Reset = 1'b1;
        repeat (20) @(negedge Clk);
        init_expect();
        check_init_points("midreset_init");
    endtask

    task automatic test_height_saturation();
        int dc, df, oc; logic [8:0] lf; logic [9:0] a, b;
        for (int f = 0; f < 2114; f++) run_frame(5'd31, 0, 23, dc, df, oc, lf, a, b);
        n_checks++;
        if (bus.height !== 16'd65534) begin
            n_fail++;
            $display("FAIL height_before_sat: got %0d expected 65534", bus.height);
        end
        run_frame(5'd31, 0, 23, dc, df, oc, lf, a, b);
        n_checks++;
        if (bus.height !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL height_saturate: got %0d expected 65535", bus.height);
        end
        run_frame(5'd31, 0, 23, dc, df, oc, lf, a, b);
        n_checks++;
        if (bus.height !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL height_hold_sat: got %0d expected 65535", bus.height);
        end
    endtask

    initial begin
        test_reset();
        test_read_port();
        test_scroll();
        test_wrap();
        test_overrun();
        test_zero_scroll();
        test_reset_mid_update();
        test_height_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
